// File: rtl/minimips_pkg.sv
// Shared encodings, FSM state type and decode helper for the MiniMIPS instruction issuer.
package minimips_pkg;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_LW    = 4'b1000;
  localparam logic [3:0] OP_SW    = 4'b1001;

  localparam logic [2:0] FN_AND = 3'b000;
  localparam logic [2:0] FN_ADD = 3'b001;
  localparam logic [2:0] FN_SUB = 3'b010;
  localparam logic [2:0] FN_XOR = 3'b011;
  localparam logic [2:0] FN_NOR = 3'b100;
  localparam logic [2:0] FN_OR  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // True for R-type with a defined funct, lw and sw; everything else is undefined.
  function automatic logic is_defined_instr(input logic [15:0] instr);
    logic ok;
    ok = 1'b0;
    case (instr[15:12])
      OP_RTYPE: begin
        case (instr[2:0])
          FN_AND, FN_ADD, FN_SUB, FN_XOR, FN_NOR, FN_OR: ok = 1'b1;
          default:                                       ok = 1'b0;
        endcase
      end
      OP_LW, OP_SW: ok = 1'b1;
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/minimips_prog_mem.sv
// Program RAM: one synchronous write port, one registered read port.
module minimips_prog_mem #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/minimips_instr_issuer.sv
// Sequences a program memory through a PC and presents each defined MiniMIPS word
// to the core under valid/ready, stopping on a halt word or at the end of memory.
module minimips_instr_issuer
  import minimips_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [15:0]       prog_data,
  output logic [15:0]       instruction,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic              illegal
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [15:0]       r_instruction;
  logic [15:0]       w_instruction_nxt;
  logic              r_instr_valid;
  logic              r_busy;
  logic              r_done;
  logic              r_illegal;
  logic              w_illegal_nxt;
  logic              w_prog_en;
  logic [15:0]       w_rdata;

  // Read address follows the next PC so the word is ready during FETCH.
  minimips_prog_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (16)
  ) u_prog_mem (
    .clk     (clk),
    .i_we    (w_prog_en),
    .i_waddr (prog_addr),
    .i_wdata (prog_data),
    .i_raddr (w_pc_nxt),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_pc          <= '0;
      r_instruction <= '0;
      r_instr_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_illegal     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_instruction <= w_instruction_nxt;
      r_instr_valid <= (w_state_nxt == ST_ISSUE);
      r_busy        <= (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_ISSUE);
      r_done        <= (w_state_nxt == ST_DONE);
      r_illegal     <= w_illegal_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_instruction_nxt = r_instruction;
    w_illegal_nxt     = r_illegal;
    w_prog_en         = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        w_prog_en = prog_we;
        if (start) begin
          w_state_nxt   = ST_FETCH;
          w_pc_nxt      = '0;
          w_illegal_nxt = 1'b0;
        end
      end
      ST_FETCH: begin
        w_instruction_nxt = w_rdata;
        if (w_rdata == HALT_WORD) begin
          w_state_nxt = ST_DONE;
        end else if (!is_defined_instr(w_rdata)) begin
          // Undefined words are skipped in place, one cycle each.
          w_illegal_nxt = 1'b1;
          if (r_pc == LAST_ADDR) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_pc_nxt = r_pc + ADDR_W'(1);
          end
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (instr_ready) begin
          if (r_pc == LAST_ADDR) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_FETCH;
            w_pc_nxt    = r_pc + ADDR_W'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign instruction = r_instruction;
  assign instr_valid = r_instr_valid;
  assign pc          = r_pc;
  assign busy        = r_busy;
  assign done        = r_done;
  assign illegal     = r_illegal;

endmodule
